assoc_cache_sys: RTL and testbench
==================================

ASSOC_CACHE_SYS -- requirements
Module: assoc_cache_sys

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  MEM_WIDTH 32 -- data word width, bits
  MEM_DEPTH 1024 -- main memory depth, words; ADDR = clog2(MEM_DEPTH)
  CACHE_BLOCK 128 -- line size, bits; WORDS = CACHE_BLOCK/MEM_WIDTH, OFFSET = clog2(WORDS)
  CACHE_SIZE 512 -- cache capacity, bytes
  WAYS 2 -- associativity, power of 2 in {1,2,4}; SETS = CACHE_SIZE*8/CACHE_BLOCK/WAYS, INDEX = clog2(SETS), TAG = ADDR-INDEX-OFFSET
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rstn  in  1  asynchronous active-low reset
  memRd  in  1  CPU read request
  memWr  in  1  CPU write request
  addr  in  ADDR  CPU word address: {tag, index, offset}
  w_data  in  MEM_WIDTH  CPU write data
  r_data  out  MEM_WIDTH  CPU read data
  stall  out  1  CPU must hold its request
  mm_req  out  1  main memory block request
  mm_we  out  1  1 = block write-back, 0 = block fill
  mm_addr  out  ADDR-OFFSET  main memory block address
  mm_w_block  out  CACHE_BLOCK  write-back line data
  mm_r_block  in  CACHE_BLOCK  fill line data, valid with mm_ack
  mm_ack  in  1  one-cycle completion pulse from main memory

Function
REQ-003 Per line storage: valid, dirty, TAG bits, CACHE_BLOCK data; per set: one age field of clog2(WAYS) bits per way (true LRU, 0 = MRU).
REQ-004 Lookup is combinational on addr in IDLE; hit = any way in set with valid and matching tag.
REQ-005 Read hit: r_data = addressed word of hit line in the same cycle, stall=0, zero extra latency.
REQ-006 Write hit: at the clk edge, addressed word is written, dirty=1, stall=0.
REQ-007 Any hit updates LRU at the clk edge: hit way age := 0, ways younger than it increment, others unchanged.
REQ-008 FSM states: IDLE, WRITEBACK, FILL.
REQ-009 IDLE and miss: stall=1 combinationally; victim = lowest-numbered invalid way, else the way with maximum age; next state WRITEBACK if victim valid and dirty, else FILL.
REQ-010 WRITEBACK: mm_req=1, mm_we=1, mm_addr={victim tag, index}, mm_w_block=victim data, held stable until mm_ack; on mm_ack go to FILL.
REQ-011 FILL: mm_req=1, mm_we=0, mm_addr=addr[ADDR-1:OFFSET]; on mm_ack write mm_r_block into victim, valid=1, dirty=0, tag loaded; go to IDLE.
REQ-012 On return to IDLE the held request hits and completes per REQ-005/006; miss latency = ack delays + 1 cycle.
REQ-013 stall=1 in WRITEBACK and FILL; mm_req=0 in IDLE.
REQ-014 memRd and memWr both high SHALL be treated as a write; neither high: no state change, stall=0.
REQ-015 mm_ack while mm_req=0 SHALL be ignored.
REQ-016 r_data SHALL be 0 when memRd=0 or stall=1.
REQ-017 The CPU holds addr/w_data/memRd/memWr stable while stall=1; the block need not tolerate changes.

Reset
REQ-018 rstn low SHALL immediately (asynchronously) force: FSM=IDLE, all valid and dirty=0, way w age=w, mm_req=0, mm_we=0, mm_addr=0, mm_w_block=0, stall=0, r_data=0.
REQ-019 Reset mid-WRITEBACK/FILL SHALL abandon the transfer; no line is marked valid and dirty data is lost.
REQ-020 Data arrays need no reset.

Verification (defaults: SETS=16, index=addr[5:2], tag=addr[9:6])
REQ-021 Cold read: reset, memRd addr=0x010 -> stall=1, mm_req=1, mm_we=0, mm_addr=0x04; ack with word0=0x11111111 -> next cycle stall=0, r_data=0x11111111.
REQ-022 Hit latency: repeat read 0x010 -> stall=0 and r_data valid in the same cycle, mm_req stays 0.
REQ-023 Write-back: write 0xDEADBEEF to 0x010, fill 0x110, then read 0x210 -> WRITEBACK with mm_we=1, mm_addr=0x04, mm_w_block word0=0xDEADBEEF, then FILL mm_addr=0x84.
REQ-024 LRU: fill 0x010 and 0x110 (clean), read 0x010, read 0x210 -> no WRITEBACK, 0x110's way evicted; read 0x010 then hits with stall=0.
REQ-025 Reset during FILL (mm_req=1): drop rstn -> mm_req=0, stall=0 in the same cycle; after release, read 0x010 misses again.
REQ-026 Simultaneous memRd=memWr=1 on a hit at 0x010 with w_data=0x5A5A5A5A -> a subsequent read returns 0x5A5A5A5A and that line's dirty=1.

Source files
------------

// File: rtl/assoc_cache_sys.sv
// Set-associative write-back cache with true-LRU replacement, sitting between a
// CPU word port and a block-wide main memory port.
module assoc_cache_sys #(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int CACHE_BLOCK = 128,
  parameter int CACHE_SIZE  = 512,
  parameter int WAYS        = 2,
  localparam int ADDR   = $clog2(MEM_DEPTH),
  localparam int WORDS  = CACHE_BLOCK / MEM_WIDTH,
  localparam int OFFSET = $clog2(WORDS),
  localparam int SETS   = CACHE_SIZE * 8 / CACHE_BLOCK / WAYS,
  localparam int INDEX  = $clog2(SETS),
  localparam int TAG    = ADDR - INDEX - OFFSET,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    memRd,
  input  logic                    memWr,
  input  logic [ADDR-1:0]         addr,
  input  logic [MEM_WIDTH-1:0]    w_data,
  output logic [MEM_WIDTH-1:0]    r_data,
  output logic                    stall,
  output logic                    mm_req,
  output logic                    mm_we,
  output logic [ADDR-OFFSET-1:0]  mm_addr,
  output logic [CACHE_BLOCK-1:0]  mm_w_block,
  input  logic [CACHE_BLOCK-1:0]  mm_r_block,
  input  logic                    mm_ack,
  output logic [1:0]              fsm_state
);

  // Memory handshake: mm_req/mm_we/mm_addr/mm_w_block stay constant while
  // mm_req=1; one mm_ack pulse completes the transfer; mm_ack with mm_req=0 is ignored.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_FILL = 2'd2} state_t;
  state_t state_q, state_d;

  logic                              valid_q [SETS][WAYS];
  logic                              dirty_q [SETS][WAYS];
  logic [WAY_W-1:0]                  age_q   [SETS][WAYS];
  logic [TAG-1:0]                    tag_q   [SETS][WAYS];
  logic [WORDS-1:0][MEM_WIDTH-1:0]   data_q  [SETS][WAYS];

  logic [INDEX-1:0]  idx;
  logic [TAG-1:0]    tag_in;
  logic [OFFSET-1:0] off;
  logic              req, hit, found_inv;
  logic [WAY_W-1:0]  hit_way, victim, victim_q;
  logic              hit_acc, miss_start, fill_done;

  assign idx        = addr[OFFSET +: INDEX];
  assign tag_in     = addr[ADDR-1 -: TAG];
  assign off        = addr[OFFSET-1:0];
  assign req        = memRd | memWr;
  assign hit_acc    = (state_q == S_IDLE) && req && hit;
  assign miss_start = (state_q == S_IDLE) && req && !hit;
  assign fill_done  = (state_q == S_FILL) && mm_ack;
  assign fsm_state  = state_q;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag_in) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Invalid ways are used lowest-first; otherwise the oldest way is replaced.
  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[idx][w] && !found_inv) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (miss_start)
                state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? S_WB : S_FILL;
      S_WB:   if (mm_ack) state_d = S_FILL;
      S_FILL: if (mm_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    r_data     = '0;
    mm_req     = 1'b0;
    mm_we      = 1'b0;
    mm_addr    = '0;
    mm_w_block = '0;
    case (state_q)
      S_IDLE: begin
        stall = rstn & req & ~hit;
        if (rstn && memRd && hit) r_data = data_q[idx][hit_way][off];
      end
      S_WB: begin
        stall      = 1'b1;
        mm_req     = 1'b1;
        mm_we      = 1'b1;
        mm_addr    = {tag_q[idx][victim_q], idx};
        mm_w_block = data_q[idx][victim_q];
      end
      S_FILL: begin
        stall   = 1'b1;
        mm_req  = 1'b1;
        mm_addr = addr[ADDR-1:OFFSET];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (miss_start) victim_q <= victim;
      if (hit_acc) begin
        if (memWr) dirty_q[idx][hit_way] <= 1'b1;
        // Hit way becomes MRU; only ways more recent than it age by one.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)
            age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][hit_way])
            age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
        end
      end
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_acc && memWr) data_q[idx][hit_way][off] <= w_data;
    if (fill_done) begin
      data_q[idx][victim_q] <= mm_r_block;
      tag_q[idx][victim_q]  <= tag_in;
    end
  end

endmodule

// File: tb/tb_assoc_cache_sys.sv
// Bench for assoc_cache_sys: directed scenarios plus random traffic checked
// against a recency-stamped line model and a bench-side main memory.
module tb_assoc_cache_sys;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         memRd = 1'b0, memWr = 1'b0;
  logic [9:0]   addr = '0;
  logic [31:0]  w_data = '0;
  logic [31:0]  r_data;
  logic         stall, mm_req, mm_we, mm_ack = 1'b0;
  logic [7:0]   mm_addr;
  logic [127:0] mm_w_block, mm_r_block = '0;
  logic [1:0]   fsm_state;

  assoc_cache_sys dut (
    .clk(clk), .rstn(rstn), .memRd(memRd), .memWr(memWr), .addr(addr),
    .w_data(w_data), .r_data(r_data), .stall(stall), .mm_req(mm_req),
    .mm_we(mm_we), .mm_addr(mm_addr), .mm_w_block(mm_w_block),
    .mm_r_block(mm_r_block), .mm_ack(mm_ack), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [127:0] mem_blk [256];
  bit           m_valid [16][2];
  bit           m_dirty [16][2];
  logic [3:0]   m_tag   [16][2];
  logic [127:0] m_data  [16][2];
  int           m_time  [16][2];
  int           stamp = 0;

  bit           exp_on = 1'b0;
  logic         exp_stall, exp_req, exp_we;
  logic [31:0]  exp_rdata;
  logic [7:0]   exp_maddr;
  bit           exp_chk_blk;
  logic [127:0] exp_blk;

  logic [7:0]   wb_addr_q[$];
  logic [127:0] wb_blk_q[$];
  logic [7:0]   fill_addr_q[$];
  logic [31:0]  last_rdata = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("stall", stall, exp_stall);
      chk("r_data", r_data, exp_rdata);
      chk("mm_req", mm_req, exp_req);
      chk("mm_we", mm_we, exp_we);
      chk("mm_addr", mm_addr, exp_maddr);
      if (exp_chk_blk) chk("mm_w_block", mm_w_block, exp_blk);
    end
    if (rstn && mm_req && mm_ack) begin
      if (mm_we) begin
        wb_addr_q.push_back(mm_addr);
        wb_blk_q.push_back(mm_w_block);
      end else begin
        fill_addr_q.push_back(mm_addr);
      end
    end
    if (rstn && !stall && memRd) last_rdata = r_data;
  end

  task automatic set_exp(input logic s, input logic [31:0] rd, input logic rq, input logic we,
                         input logic [7:0] ma, input bit cb, input logic [127:0] b);
    exp_on = 1'b1; exp_stall = s; exp_rdata = rd; exp_req = rq; exp_we = we;
    exp_maddr = ma; exp_chk_blk = cb; exp_blk = b;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 2; i++) begin
        m_valid[s][i] = 1'b0;
        m_dirty[s][i] = 1'b0;
      end
  endtask

  function automatic int find(int s, logic [3:0] t);
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) return i;
    return -1;
  endfunction

  function automatic int pick_victim(int s);
    for (int i = 0; i < 2; i++)
      if (!m_valid[s][i]) return i;
    return (m_time[s][0] < m_time[s][1]) ? 0 : 1;
  endfunction

  task automatic do_reset();
    exp_on = 1'b0;
    rstn = 1'b0; memRd = 1'b1; memWr = 1'b0; addr = 10'h010; mm_ack = 1'b0;
    #1;
    chk("reset stall", stall, 0);
    chk("reset r_data", r_data, 0);
    chk("reset mm_req", mm_req, 0);
    chk("reset mm_we", mm_we, 0);
    chk("reset mm_addr", mm_addr, 0);
    chk("reset mm_w_block", mm_w_block, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; memRd = 1'b0;
    model_clear();
    cycle();
  endtask

  task automatic idle(input int n);
    memRd = 1'b0; memWr = 1'b0;
    for (int i = 0; i < n; i++) begin
      addr = 10'($urandom);
      set_exp(0, 0, 0, 0, 0, 0, 0);
      mm_ack = 1'($urandom_range(0, 1));
      cycle();
    end
    mm_ack = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input bit abort, output bit missed);
    int s, o, sl, v, k;
    logic [3:0] t;
    logic [7:0] blk;
    logic [31:0] word;
    s = int'(a[5:2]); t = a[9:6]; o = int'(a[1:0]); blk = a[9:2];
    memRd = rd; memWr = wr; addr = a; w_data = d; missed = 1'b0;
    sl = find(s, t);
    if (sl < 0) begin
      missed = 1'b1;
      v = pick_victim(s);
      set_exp(1, 0, 0, 0, 0, 0, 0);
      mm_ack = 1'($urandom_range(0, 1));
      cycle();
      mm_ack = 1'b0;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        k = $urandom_range(0, 3);
        for (int i = 0; i <= k; i++) begin
          set_exp(1, 0, 1, 1, {m_tag[s][v], 4'(s)}, 1, m_data[s][v]);
          mm_r_block = {$urandom, $urandom, $urandom, $urandom};
          mm_ack = (i == k);
          cycle();
        end
        mm_ack = 1'b0;
        mem_blk[{m_tag[s][v], 4'(s)}] = m_data[s][v];
      end
      k = $urandom_range(0, 3);
      for (int i = 0; i <= k; i++) begin
        if (abort) begin
          chk("fill mm_req before reset", mm_req, 1);
          exp_on = 1'b0;
          rstn = 1'b0;
          #1;
          chk("abort mm_req", mm_req, 0);
          chk("abort stall", stall, 0);
          chk("abort r_data", r_data, 0);
          memRd = 1'b0; memWr = 1'b0;
          model_clear();
          @(negedge clk);
          rstn = 1'b1;
          cycle();
          return;
        end
        set_exp(1, 0, 1, 0, blk, 0, 0);
        mm_r_block = mem_blk[blk];
        mm_ack = (i == k);
        cycle();
      end
      mm_ack = 1'b0;
      m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_tag[s][v] = t; m_data[s][v] = mem_blk[blk];
      sl = v;
    end
    word = m_data[s][sl][o*32 +: 32];
    set_exp(0, rd ? word : 32'h0, 0, 0, 0, 0, 0);
    mm_ack = 1'($urandom_range(0, 1));
    cycle();
    mm_ack = 1'b0;
    if (wr) begin
      m_data[s][sl][o*32 +: 32] = d;
      m_dirty[s][sl] = 1'b1;
    end
    stamp++;
    m_time[s][sl] = stamp;
    memRd = 1'b0; memWr = 1'b0;
  endtask

  task automatic clear_logs();
    wb_addr_q.delete(); wb_blk_q.delete(); fill_addr_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    logic [127:0] tmp;
    logic [9:0] a;
    int op;
    for (int i = 0; i < 256; i++) mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blk[8'h04][31:0] = 32'h11111111;

    // cold read, then hit
    do_reset();
    clear_logs();
    access(1, 0, 10'h010, 0, 0, m);
    chk("cold miss", m, 1);
    chk("cold rdata", last_rdata, 32'h11111111);
    chk("cold fill addr", fill_addr_q.size() == 1 ? fill_addr_q[0] : 8'hFF, 8'h04);
    access(1, 0, 10'h010, 0, 0, m);
    chk("hit no miss", m, 0);
    chk("hit rdata", last_rdata, 32'h11111111);

    // dirty line written back when evicted
    do_reset();
    clear_logs();
    access(0, 1, 10'h010, 32'hDEADBEEF, 0, m);
    access(1, 0, 10'h110, 0, 0, m);
    clear_logs();
    access(1, 0, 10'h210, 0, 0, m);
    chk("wb count", wb_addr_q.size(), 1);
    tmp = (wb_blk_q.size() > 0) ? wb_blk_q[0] : '0;
    chk("wb addr", wb_addr_q.size() > 0 ? wb_addr_q[0] : 8'hFF, 8'h04);
    chk("wb word0", tmp[31:0], 32'hDEADBEEF);
    chk("wb then fill addr", fill_addr_q.size() > 0 ? fill_addr_q[0] : 8'hFF, 8'h84);

    // LRU victim selection with clean lines
    do_reset();
    access(1, 0, 10'h010, 0, 0, m);
    access(1, 0, 10'h110, 0, 0, m);
    access(1, 0, 10'h010, 0, 0, m);
    clear_logs();
    access(1, 0, 10'h210, 0, 0, m);
    chk("lru no wb", wb_addr_q.size(), 0);
    access(1, 0, 10'h010, 0, 0, m);
    chk("lru keeps mru", m, 0);
    access(1, 0, 10'h110, 0, 0, m);
    chk("lru evicted older", m, 1);

    // reset in the middle of a fill
    do_reset();
    access(1, 0, 10'h010, 0, 1, m);
    access(1, 0, 10'h010, 0, 0, m);
    chk("miss after abort", m, 1);

    // read and write together act as a write
    do_reset();
    access(1, 0, 10'h010, 0, 0, m);
    access(1, 1, 10'h010, 32'h5A5A5A5A, 0, m);
    chk("rw hit", m, 0);
    access(1, 0, 10'h010, 0, 0, m);
    chk("rw readback", last_rdata, 32'h5A5A5A5A);
    access(1, 0, 10'h110, 0, 0, m);
    clear_logs();
    access(1, 0, 10'h210, 0, 0, m);
    tmp = (wb_blk_q.size() > 0) ? wb_blk_q[0] : '0;
    chk("rw dirty wb addr", wb_addr_q.size() > 0 ? wb_addr_q[0] : 8'hFF, 8'h04);
    chk("rw dirty wb word0", tmp[31:0], 32'h5A5A5A5A);

    // random traffic over a few conflicting sets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 2));
      a = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      access(op != 2, op >= 2, a, $urandom, 0, m);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
